// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush scheduler.
// Stall vectors are built from STOP/NOSTOP so that bit ordering stays PC..WB, LSB first.
package pipe_stall_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [5:0] STALL_NONE = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP};
  localparam logic [5:0] STALL_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP,   STOP,   STOP};
  localparam logic [5:0] STALL_EX   = {NOSTOP, NOSTOP, STOP,   STOP,   STOP,   STOP};
  localparam logic [5:0] STALL_MEM  = {NOSTOP, STOP,   STOP,   STOP,   STOP,   STOP};

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_EX_BUSY  = 2'd1,
    CTRL_MEM_WAIT = 2'd2
  } ctrl_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter32.sv
// 32-bit saturating event counter with synchronous active-low clear.
// CLR_VAL is the value loaded on clear (normally zero).
module sat_counter32
  import pipe_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] CLR_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt <= CLR_VAL;
    end else if (en) begin
      cnt <= sat_inc32(cnt);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: merges ID/EX/MEM stall
// requests and flushes into one stall vector, with EX occupancy and bus-wait timeout.
//
//   state         | meaning
//   --------------+-------------------------------------------------------------
//   CTRL_RUN      | normal issue; requests arbitrated flush > MEM > EX > ID
//   CTRL_EX_BUSY  | multi-cycle EX op in flight, remain counts down to 1
//   CTRL_MEM_WAIT | MEM stalled on bus; wait_left counts down to timeout
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT       = 255,
  parameter int unsigned LEN_W          = 6,
  parameter logic [31:0] STALL_CNT_INIT = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [LEN_W-1:0] ex_mc_len,
  input  logic             mem_stallreq,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             ex_busy,
  output logic             bus_timeout,
  output logic [31:0]      stall_cnt
);

  // Entry cycle already counts as the first wait cycle, so the timer loads MAX_WAIT-1.
  localparam logic [15:0] WAIT_LOAD = 16'(MAX_WAIT - 1);

  ctrl_state_e      state, state_nxt;
  logic [LEN_W-1:0] remain, remain_nxt;
  logic [15:0]      wait_left, wait_nxt;
  logic             flush_pend, pend_nxt;
  logic             mem_mask;
  logic             mem_req;
  logic             timeout_c;
  logic             run_rules, run_mem, run_flush;
  logic [5:0]       stall_c;
  logic             flush_c;

  assign mem_req = mem_stallreq & ~mem_mask;

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    wait_nxt   = wait_left;
    pend_nxt   = flush_pend;
    stall_c    = STALL_NONE;
    flush_c    = 1'b0;
    timeout_c  = 1'b0;
    run_rules  = 1'b0;
    run_mem    = mem_req;
    run_flush  = flush_req;

    case (state)
      CTRL_RUN: begin
        run_rules = 1'b1;
      end
      CTRL_EX_BUSY: begin
        if (flush_req) begin
          flush_c    = 1'b1;
          remain_nxt = '0;
          state_nxt  = CTRL_RUN;
        end else begin
          stall_c    = mem_req ? STALL_MEM : STALL_EX;
          remain_nxt = remain - LEN_W'(1);
          if (remain == LEN_W'(1)) state_nxt = CTRL_RUN;
        end
      end
      CTRL_MEM_WAIT: begin
        if (mem_req && (wait_left != 16'd0)) begin
          stall_c  = STALL_MEM;
          wait_nxt = wait_left - 16'd1;
          if (flush_req) pend_nxt = 1'b1;
        end else begin
          // Leaving on bus release or timeout: arbitrate as RUN in this same cycle,
          // with the timed-out request masked and any deferred flush issued now.
          timeout_c = mem_req;
          run_rules = 1'b1;
          run_mem   = 1'b0;
          run_flush = flush_req | flush_pend;
          pend_nxt  = 1'b0;
          wait_nxt  = '0;
          state_nxt = CTRL_RUN;
        end
      end
      default: begin
        state_nxt = CTRL_RUN;
      end
    endcase

    if (run_rules) begin
      if (run_flush) begin
        flush_c   = 1'b1;
        state_nxt = CTRL_RUN;
      end else if (run_mem) begin
        stall_c   = STALL_MEM;
        wait_nxt  = WAIT_LOAD;
        state_nxt = CTRL_MEM_WAIT;
      end else if (ex_mc_start && (ex_mc_len >= LEN_W'(2))) begin
        stall_c    = STALL_EX;
        remain_nxt = ex_mc_len - LEN_W'(1);
        state_nxt  = CTRL_EX_BUSY;
      end else if (stallreq_id) begin
        stall_c = STALL_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= CTRL_RUN;
      remain      <= '0;
      wait_left   <= '0;
      flush_pend  <= 1'b0;
      mem_mask    <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      remain      <= remain_nxt;
      wait_left   <= wait_nxt;
      flush_pend  <= pend_nxt;
      mem_mask    <= timeout_c | (mem_mask & mem_stallreq);
      bus_timeout <= timeout_c;
    end
  end

  assign stall   = rst ? stall_c : STALL_NONE;
  assign flush   = rst & flush_c;
  assign ex_busy = (state == CTRL_EX_BUSY);

  sat_counter32 #(
    .CLR_VAL (STALL_CNT_INIT)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (stall[0]),
    .cnt (stall_cnt)
  );

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Merges stall requests from ID (load-use), EX (multi-cycle ops such as div/madd) and MEM (bus wait), plus exception/flush requests.
- Produces the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, and a one-cycle flush.
- Sequences multi-cycle EX occupancy, detects bus-wait timeouts and keeps a stall performance counter.

Parameters:
- MAX_WAIT, 255: maximum consecutive MEM wait cycles before timeout (2..65535).
- LEN_W, 6: width of the multi-cycle length field.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
- stallreq_id  in  1  ID load-use hazard request
- ex_mc_start  in  1  one-cycle pulse: EX began multi-cycle op
- ex_mc_len  in  LEN_W  total EX cycles of that op, sampled with ex_mc_start
- mem_stallreq  in  1  MEM waiting on bus
- flush_req  in  1  exception/flush request, level
- stall  out  6  stall vector; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB; 1=STOP
- flush  out  1  pipeline flush, one cycle
- ex_busy  out  1  high while in EX_BUSY
- bus_timeout  out  1  one-cycle registered pulse on MEM wait timeout
- stall_cnt  out  32  saturating count of cycles with stall[0]==1

Behaviour:
- Stall encodings: NONE=000000, ID=000111, EX=001111, MEM=011111. stall[5] is never asserted.
- stall and flush are combinational (Mealy) from state plus current inputs, so the pipeline registers see them in the same cycle. Both are forced to 0 while rst==0.
- Reset values: state=RUN, remain=0, wait_cnt=0, flush_pend=0, mem_mask=0, bus_timeout=0, stall_cnt=0.
- States: RUN, EX_BUSY, MEM_WAIT.
- Effective MEM request: mem_req = mem_stallreq & ~mem_mask.
- RUN, priority high to low:
  - flush_req: flush=1, stall=NONE, stay in RUN.
  - mem_req: stall=MEM, go to MEM_WAIT, wait_cnt=1.
  - ex_mc_start with len>=2: stall=EX, go to EX_BUSY, remain=len-1.
  - ex_mc_start with len 0 or 1 is a single-cycle op: no stall.
  - stallreq_id: stall=ID.
  - Otherwise NONE.
- EX_BUSY:
  - stall=EX, or MEM if mem_req.
  - remain decrements every cycle; when remain==1, go to RUN next cycle.
  - Total stalled cycles equal len, including the start cycle.
  - ex_mc_start and stallreq_id are ignored.
  - flush_req: flush=1, stall=NONE, remain=0, go to RUN.
- MEM_WAIT:
  - While mem_req is high: stall=MEM, wait_cnt increments.
  - When mem_stallreq drops: RUN rules apply in that same cycle (combinational); state goes to RUN and wait_cnt clears.
  - flush_req is not honoured here; it sets flush_pend. On leaving MEM_WAIT, flush=1 is issued on the exit cycle and flush_pend clears.
  - If wait_cnt==MAX_WAIT and mem_stallreq is still high:
    - bus_timeout pulses on the next cycle.
    - state goes to RUN and mem_mask sets.
    - mem_mask clears when mem_stallreq is low.
- ex_busy = (state==EX_BUSY).
- stall_cnt increments on each clk where stall[0]==1 and saturates at 0xFFFFFFFF; it does not wrap.
- Reset mid-operation: all state is abandoned and the next cycle is in RUN with stall=NONE. Pending flush is lost.
- Simultaneous events:
  - In RUN, flush beats MEM, MEM beats EX, EX beats ID. ex_mc_start is lost if mem_req wins; EX must re-pulse it.
  - In EX_BUSY, flush aborts.

Decomposition:
- macro.v gains:
  - STALL_NONE/ID/EX/MEM vector constants
  - CTRL_RUN/EX_BUSY/MEM_WAIT state encodings
  - reuse of the existing STOP/NOSTOP definitions
- One natural sub-module: sat_counter32 (enable, synchronous active-low clear, saturating), instantiated for stall_cnt.

Test Plan:
- Reset: hold rst=0 for 3 cycles with every request high -> stall=000000, flush=0, stall_cnt=0; first cycle after release with idle inputs -> stall=000000.
- Multi-cycle EX: ex_mc_start=1, ex_mc_len=5 in RUN -> stall=001111 for exactly 5 cycles starting the start cycle, ex_busy high for 4 cycles, stall_cnt=5 afterwards.
- Flush during EX_BUSY: len=10, flush_req at cycle 3 -> that cycle flush=1, stall=000000; next cycle state RUN, ex_busy=0.
- Priority: stallreq_id=1, ex_mc_start=1 (len 4), mem_stallreq=1 together in RUN -> stall=011111, MEM_WAIT entered, no EX_BUSY.
- Timeout: MAX_WAIT=4, mem_stallreq held high 10 cycles -> stall=011111 for 4 cycles, bus_timeout pulses once, then stall=000000 until mem_stallreq falls and is re-raised.
- Pending flush: flush_req pulsed during MEM_WAIT, mem_stallreq drops 3 cycles later -> flush=1 exactly on the exit cycle; stall_cnt saturation preloaded to 0xFFFFFFFE with 3 stall cycles -> ends at 0xFFFFFFFF.
